// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the ID/EX pipeline stages and pipe_hazard_ctrl.
// Pipeline side (master) drives decode/EX hazard info; controller (slave) returns enables, flushes, MDU control.
// Ports: ID_* decode fields, ID_EX_* EX-stage load/writeback info, EX_Redirect, PC/IF_ID enables, flushes, Mdu*.
interface pipe_hazard_ctrl_if;
  logic [4:0] ID_rs;
  logic [4:0] ID_rt;
  logic       ID_UseRs;
  logic       ID_UseRt;
  logic       ID_IsMdu;
  logic       ID_IsDiv;
  logic       ID_IsHiLo;
  logic       ID_EX_MemRd;
  logic       ID_EX_RfWr;
  logic [4:0] ID_EX_rw;
  logic       EX_Redirect;
  logic       PC_Wr;
  logic       IF_ID_Wr;
  logic       IF_ID_Flush;
  logic       ID_EX_Flush;
  logic       MduStart;
  logic       MduIsDiv;
  logic       MduBusy;

  modport master (
    output ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_IsMdu, ID_IsDiv, ID_IsHiLo,
           ID_EX_MemRd, ID_EX_RfWr, ID_EX_rw, EX_Redirect,
    input  PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush, MduStart, MduIsDiv, MduBusy
  );

  modport slave (
    input  ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_IsMdu, ID_IsDiv, ID_IsHiLo,
           ID_EX_MemRd, ID_EX_RfWr, ID_EX_rw, EX_Redirect,
    output PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush, MduStart, MduIsDiv, MduBusy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, MDU scheduling/interlock, EX branch/jump flushes.
// Latency: enables/flushes combinational; MduStart/MduIsDiv registered (one cycle after issue); MduBusy = FSM state.
// Backpressure: stalls PC and IF/ID and injects an ID/EX bubble on load-use or while the MDU is busy.
// Ports: clk, rst_n (async active-low), hz (slave modport of pipe_hazard_ctrl_if).
// Optional macro HAZ_PERF_CNT_EN adds StallCnt/FlushCnt 32-bit wrapping event counters.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]        StallCnt,
  output logic [31:0]        FlushCnt
`endif
);

  typedef enum logic {MDU_IDLE = 1'b0, MDU_BUSY = 1'b1} mdu_state_t;

  localparam logic [4:0] MUL_CNT = 5'(MUL_LAT);
  localparam logic [4:0] DIV_CNT = 5'(DIV_LAT);

  mdu_state_t state_q;
  logic [4:0] cnt_q;
  logic       mdu_start_q;
  logic       mdu_is_div_q;

  logic lu_haz;
  logic mdu_haz;
  logic stall;
  logic advance;

  // r0 is hardwired zero, so a load "writing" r0 never creates a dependency.
  assign lu_haz = hz.ID_EX_MemRd & hz.ID_EX_RfWr & (hz.ID_EX_rw != 5'd0) &
                  ((hz.ID_UseRs & (hz.ID_rs == hz.ID_EX_rw)) |
                   (hz.ID_UseRt & (hz.ID_rt == hz.ID_EX_rw)));
  assign mdu_haz = (state_q == MDU_BUSY) & (hz.ID_IsMdu | hz.ID_IsHiLo);
  // A redirect means the ID instruction is wrong-path, so its hazards are moot.
  assign stall   = (lu_haz | mdu_haz) & ~hz.EX_Redirect;
  assign advance = hz.ID_IsMdu & ~stall & ~hz.EX_Redirect;

  always_comb begin
    hz.PC_Wr       = 1'b1;
    hz.IF_ID_Wr    = 1'b1;
    hz.IF_ID_Flush = 1'b0;
    hz.ID_EX_Flush = 1'b0;
    if (hz.EX_Redirect) begin
      hz.IF_ID_Flush = 1'b1;
      hz.ID_EX_Flush = 1'b1;
    end else if (stall) begin
      hz.PC_Wr       = 1'b0;
      hz.IF_ID_Wr    = 1'b0;
      hz.ID_EX_Flush = 1'b1;
    end
  end

  assign hz.MduStart = mdu_start_q;
  assign hz.MduIsDiv = mdu_is_div_q;
  assign hz.MduBusy  = (state_q == MDU_BUSY);

  // MDU scheduler. A redirect never aborts a running op: it is older than the branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= MDU_IDLE;
      cnt_q        <= 5'd0;
      mdu_start_q  <= 1'b0;
      mdu_is_div_q <= 1'b0;
    end else begin
      mdu_start_q <= 1'b0;
      case (state_q)
        MDU_IDLE: begin
          if (advance) begin
            mdu_start_q  <= 1'b1;
            mdu_is_div_q <= hz.ID_IsDiv;
            state_q      <= MDU_BUSY;
            cnt_q        <= hz.ID_IsDiv ? DIV_CNT : MUL_CNT;
          end
        end
        MDU_BUSY: begin
          // Busy spans exactly LAT cycles: cnt walks LAT..1.
          if (cnt_q == 5'd1) begin
            state_q <= MDU_IDLE;
            cnt_q   <= 5'd0;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        default: begin
          state_q <= MDU_IDLE;
          cnt_q   <= 5'd0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall)          stall_cnt_q <= stall_cnt_q + 32'd1;
      if (hz.EX_Redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MUL_LAT=4, DIV_LAT=16).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Expected output vectors are queued when stimulus is driven and popped at sampling.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       redir;
    logic       memrd;
    logic       rfwr;
    logic [4:0] rw;
    logic       ismdu;
    logic       isdiv;
    logic       ishilo;
    logic       users;
    logic       usert;
    logic [4:0] rs;
    logic [4:0] rt;
  } in_t;

  // Expected vector layout: {PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush, MduStart, MduIsDiv, MduBusy}
  localparam logic [3:0] N = 4'b1100;
  localparam logic [3:0] S = 4'b0001;
  localparam logic [3:0] R = 4'b1111;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [6:0] exp_q[$];

  pipe_hazard_ctrl_if hif();

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  pipe_hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif)
`ifdef HAZ_PERF_CNT_EN
    ,
    .StallCnt (stall_cnt),
    .FlushCnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input in_t v);
    hif.EX_Redirect = v.redir;
    hif.ID_EX_MemRd = v.memrd;
    hif.ID_EX_RfWr  = v.rfwr;
    hif.ID_EX_rw    = v.rw;
    hif.ID_IsMdu    = v.ismdu;
    hif.ID_IsDiv    = v.isdiv;
    hif.ID_IsHiLo   = v.ishilo;
    hif.ID_UseRs    = v.users;
    hif.ID_UseRt    = v.usert;
    hif.ID_rs       = v.rs;
    hif.ID_rt       = v.rt;
  endtask

  function automatic logic [6:0] obs();
    return {hif.PC_Wr, hif.IF_ID_Wr, hif.IF_ID_Flush, hif.ID_EX_Flush,
            hif.MduStart, hif.MduIsDiv, hif.MduBusy};
  endfunction

  task automatic test_reset();
    logic [6:0] e;
    set_in('0);
    rst_n = 1'b0;
    exp_q.push_back({N, 3'b000});
    #3;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_hold got %b exp %b", obs(), e);
    end
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({N, 3'b000});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_release got %b exp %b", obs(), e);
    end
`ifdef HAZ_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    in_t st[$];
    logic [6:0] ex[$];
    in_t v;
    logic [6:0] e;
    v = '0; v.memrd = 1; v.rfwr = 1; v.rw = 5'd8; v.rs = 5'd8; v.users = 1;
    st.push_back(v); ex.push_back({S, 3'b000});
    v.memrd = 0;                                   // bubble cleared the load
    st.push_back(v); ex.push_back({N, 3'b000});
    v = '0; v.memrd = 1; v.rfwr = 1; v.rw = 5'd0; v.rs = 5'd0; v.users = 1;
    st.push_back(v); ex.push_back({N, 3'b000});    // r0 never hazards
    v = '0; v.memrd = 1; v.rfwr = 1; v.rw = 5'd9; v.rt = 5'd9; v.usert = 1;
    st.push_back(v); ex.push_back({S, 3'b000});    // rt path
    v.usert = 0;
    st.push_back(v); ex.push_back({N, 3'b000});    // field matches but unused
    v = '0; v.memrd = 1; v.rfwr = 0; v.rw = 5'd8; v.rs = 5'd8; v.users = 1;
    st.push_back(v); ex.push_back({N, 3'b000});    // load without writeback
    v = '0; v.memrd = 1; v.rfwr = 1; v.rw = 5'd8; v.rs = 5'd7; v.users = 1;
    st.push_back(v); ex.push_back({N, 3'b000});    // different register
    foreach (st[i]) begin
      set_in(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL load_use[%0d] got %b exp %b", i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mult();
    in_t st[$];
    logic [6:0] ex[$];
    in_t v;
    logic [6:0] e;
    v = '0; v.ismdu = 1;
    st.push_back(v); ex.push_back({N, 3'b000});
    v = '0; v.ishilo = 1;                          // mfhi waits for the result
    for (int i = 0; i < 4; i++) begin
      st.push_back(v); ex.push_back({S, (i == 0), 1'b0, 1'b1});
    end
    st.push_back(v); ex.push_back({N, 3'b000});
    st.push_back('0); ex.push_back({N, 3'b000});
    foreach (st[i]) begin
      set_in(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL mult[%0d] got %b exp %b", i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    in_t st[$];
    logic [6:0] ex[$];
    in_t v;
    logic [6:0] e;
    v = '0; v.ismdu = 1; v.isdiv = 1;
    st.push_back(v); ex.push_back({N, 3'b000});
    v.isdiv = 0;                                   // mult right behind the div
    for (int i = 0; i < 16; i++) begin
      st.push_back(v); ex.push_back({S, (i == 0), 1'b1, 1'b1});
    end
    st.push_back(v); ex.push_back({N, 3'b010});
    st.push_back('0); ex.push_back({N, 3'b101});
    for (int i = 0; i < 3; i++) begin
      st.push_back('0); ex.push_back({N, 3'b001});
    end
    st.push_back('0); ex.push_back({N, 3'b000});
    foreach (st[i]) begin
      set_in(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL div_mult[%0d] got %b exp %b", i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect_priority();
    in_t st[$];
    logic [6:0] ex[$];
    in_t v;
    logic [6:0] e;
    v = '0; v.redir = 1; v.memrd = 1; v.rfwr = 1; v.rw = 5'd8; v.rs = 5'd8;
    v.users = 1; v.ismdu = 1;
    st.push_back(v); ex.push_back({R, 3'b000});
    st.push_back('0); ex.push_back({N, 3'b000});   // MDU op was flushed: no start
    st.push_back('0); ex.push_back({N, 3'b000});
    foreach (st[i]) begin
      set_in(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL redir_prio[%0d] got %b exp %b", i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect_busy();
    in_t st[$];
    logic [6:0] ex[$];
    in_t v;
    logic [6:0] e;
    v = '0; v.ismdu = 1;
    st.push_back(v); ex.push_back({N, 3'b000});
    st.push_back('0); ex.push_back({N, 3'b101});   // cnt=4
    v = '0; v.redir = 1; v.ismdu = 1;              // cnt=3, redirect wins
    st.push_back(v); ex.push_back({R, 3'b001});
    v = '0; v.ishilo = 1; v.memrd = 1; v.rfwr = 1; v.rw = 5'd3; v.rt = 5'd3; v.usert = 1;
    st.push_back(v); ex.push_back({S, 3'b001});    // both hazards, one stall
    st.push_back('0); ex.push_back({N, 3'b001});
    st.push_back('0); ex.push_back({N, 3'b000});
    foreach (st[i]) begin
      set_in(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL redir_busy[%0d] got %b exp %b", i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    in_t st[$];
    logic [6:0] ex[$];
    in_t v;
    logic [6:0] e;
    v = '0; v.ismdu = 1; v.isdiv = 1;
    st.push_back(v); ex.push_back({N, 3'b000});
    st.push_back('0); ex.push_back({N, 3'b111});
    st.push_back('0); ex.push_back({N, 3'b011});
    st.push_back('0); ex.push_back({N, 3'b011});
    foreach (st[i]) begin
      set_in(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL arst_pre[%0d] got %b exp %b", i, obs(), e);
      end
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    exp_q.push_back({N, 3'b000});
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL arst_mid got %b exp %b", obs(), e);
    end
`ifdef HAZ_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      errors++;
      $display("FAIL arst_perf got %0d/%0d exp 0/0", stall_cnt, flush_cnt);
    end
`endif
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      set_in('0);
      exp_q.push_back({N, 3'b000});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL arst_post[%0d] got %b exp %b", i, obs(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load_use();
    test_mult();
    test_back_to_back();
    test_redirect_priority();
    test_redirect_busy();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core, sitting beside the ID/EX forwarding logic.
- Detects load-use hazards that forwarding cannot cover and drives PC/IF_ID write enables and IF_ID/ID_EX flushes.
- Schedules the shared multi-cycle mult/div unit (MDU): issues start pulses, tracks busy latency and interlocks later MDU and mfhi/mflo instructions.
- Applies branch/jump flushes resolved in EX.

Parameters:
- MUL_LAT, 4, MDU cycles for mult/multu, range 1..31.
- DIV_LAT, 16, MDU cycles for div/divu, range 1..31.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ID_rs  input  5  rs field of the instruction in ID.
- ID_rt  input  5  rt field of the instruction in ID.
- ID_UseRs  input  1  ID instruction reads rs.
- ID_UseRt  input  1  ID instruction reads rt.
- ID_IsMdu  input  1  ID instruction is mult/multu/div/divu.
- ID_IsDiv  input  1  qualifies ID_IsMdu: 1 = div/divu.
- ID_IsHiLo  input  1  ID instruction is mfhi/mflo/mthi/mtlo.
- ID_EX_MemRd  input  1  EX-stage instruction is a load.
- ID_EX_RfWr  input  1  EX-stage instruction writes the register file.
- ID_EX_rw  input  5  EX-stage write address.
- EX_Redirect  input  1  taken branch or jump resolved in EX.
- PC_Wr  output  1  PC write enable.
- IF_ID_Wr  output  1  IF/ID register write enable.
- IF_ID_Flush  output  1  clear IF/ID to a nop.
- ID_EX_Flush  output  1  clear ID/EX to a bubble.
- MduStart  output  1  registered one-cycle start pulse to the MDU.
- MduIsDiv  output  1  registered op select, valid with MduStart.
- MduBusy  output  1  MDU is computing.

Behaviour:
- State machine: MDU_IDLE, MDU_BUSY. 5-bit down-counter cnt.
- Reset (async, rst_n=0): state=MDU_IDLE, cnt=0, MduStart=0, MduIsDiv=0.
  - With all inputs at 0, outputs are PC_Wr=1, IF_ID_Wr=1, IF_ID_Flush=0, ID_EX_Flush=0, MduBusy=0.
- lu_haz (combinational) = ID_EX_MemRd & ID_EX_RfWr & ID_EX_rw!=0 & ((ID_UseRs & ID_rs==ID_EX_rw) | (ID_UseRt & ID_rt==ID_EX_rw)).
- mdu_haz (combinational) = (state==MDU_BUSY) & (ID_IsMdu | ID_IsHiLo).
- stall = (lu_haz | mdu_haz) & ~EX_Redirect.
- Output priority:
  1. EX_Redirect=1: PC_Wr=1, IF_ID_Wr=1, IF_ID_Flush=1, ID_EX_Flush=1. Stalls are ignored because the ID instruction is wrong-path.
  2. stall=1: PC_Wr=0, IF_ID_Wr=0, IF_ID_Flush=0, ID_EX_Flush=1 (bubble inserted).
  3. Otherwise: PC_Wr=1, IF_ID_Wr=1, both flushes 0.
- Load-use stall lasts exactly 1 cycle. The bubble clears ID_EX_MemRd, and the load result is then forwarded from MEM/WB.
- MDU issue: advance = ID_IsMdu & ~stall & ~EX_Redirect.
  - On a clock edge with advance=1: MduStart<=1, MduIsDiv<=ID_IsDiv, state<=MDU_BUSY, cnt<=ID_IsDiv ? DIV_LAT : MUL_LAT.
  - Otherwise MduStart<=0.
- MDU_BUSY: cnt decrements each edge. When cnt==1, the next edge sets state<=MDU_IDLE and cnt<=0.
  - MduBusy = (state==MDU_BUSY), so it is high for exactly LAT cycles starting the cycle MduStart is high.
  - A HI/LO or MDU instruction in ID proceeds in the first cycle MduBusy=0.
- Advance cannot occur while MDU_BUSY, because mdu_haz forces a stall. There are no back-to-back restarts.
- An EX_Redirect during MDU_BUSY does not abort the MDU. The MDU op is older than the branch, so counting continues.
- An MDU op in ID during EX_Redirect is flushed: no MduStart, state unchanged.
- Simultaneous lu_haz and mdu_haz: a single stall, identical outputs.
- ID_rs/ID_rt equal to 0 never produces lu_haz, because the rw!=0 guard applies.
- Reset asserted mid-MDU_BUSY returns the block to MDU_IDLE immediately. No MduStart is generated on release.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined, adds output ports StallCnt[31:0] and FlushCnt[31:0].
  - StallCnt increments on every cycle with stall=1.
  - FlushCnt increments on every cycle with EX_Redirect=1.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined, these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Load-use: ID_EX_MemRd=1, RfWr=1, rw=8, ID_rs=8, UseRs=1 -> one cycle PC_Wr=0, IF_ID_Wr=0, ID_EX_Flush=1. The next cycle (MemRd=0) has normal outputs. Repeating with rw=0 -> no stall.
- Mult issue: ID_IsMdu=1, IsDiv=0, MUL_LAT=4 -> MduStart=1 for 1 cycle, MduBusy=1 for exactly 4 cycles. An mfhi in ID during those cycles stalls 4 cycles and advances on cycle 5.
- Div issue with DIV_LAT=16 followed immediately by mult in ID -> mult stalls 16 cycles, then MduStart pulses with MduIsDiv=0.
- Redirect priority: EX_Redirect=1 together with lu_haz=1 and ID_IsMdu=1 -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Wr=1, no MduStart.
- Redirect during MDU_BUSY with cnt=3 -> flush outputs asserted, MduBusy still drops exactly 3 cycles later.
- Async reset: drop rst_n mid-divide, between clock edges -> MduBusy=0, PC_Wr=1 immediately. HAZ_PERF_CNT_EN build: StallCnt=0, FlushCnt=0.
